feature_window_reader: RTL

- Consumer end of the 8-bit first-word-fall-through (FWFT) feature buffer.
- Pops one feature map of IMG_H x IMG_W pixels in raster order using the rd_en / feature_valid handshake.
- Builds K x K sliding windows from two internal line buffers and presents one window per valid position to the convolution datapath, with backpressure.
- With defaults: 27x27 input produces 25x25 = 625 windows of 3x3 per frame.

---
 rtl/feature_window_reader.sv | 90 +++++++++
 1 files changed

// File: rtl/feature_window_reader.sv
// feature_window_reader: pops an FWFT feature map in raster order and emits K x K sliding windows
module feature_window_reader #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 27,
  parameter int IMG_H  = 27,
  parameter int K      = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     feature_valid,
  input  logic [DATA_W-1:0]        in_feature,
  output logic                     rd_en,
  input  logic                     window_ready,
  output logic                     window_valid,
  output logic [K*K*DATA_W-1:0]    window,
  output logic                     busy,
  output logic                     frame_done
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  state_t state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [K*K*DATA_W-1:0] win_q, win_d;
  logic wv_q, wv_d;
  logic [DATA_W-1:0] lb_q [K-1][IMG_W];
  logic [DATA_W-1:0] tap [K];
  logic col_last, row_last, emit;
  assign col_last     = col_q == CW'(IMG_W-1);
  assign row_last     = row_q == RW'(IMG_H-1);
  assign emit         = (row_q >= RW'(K-1)) && (col_q >= CW'(K-1));
  assign rd_en        = (state_q == RUN) & feature_valid & ~(wv_q & ~window_ready);
  assign window_valid = wv_q;
  assign window       = win_q;
  assign busy         = state_q != IDLE;
  assign frame_done   = state_q == DONE;
  // tap[0] is the oldest row, tap[K-1] the pixel being accepted
  always_comb begin
    for (int i = 0; i < K-1; i++) tap[i] = lb_q[K-2-i][col_q];
    tap[K-1] = in_feature;
  end
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    win_d   = win_q;
    wv_d    = wv_q & ~window_ready;
    case (state_q)
      IDLE:    if (start) begin
        state_d = RUN;
        col_d   = '0;
        row_d   = '0;
      end
      RUN:     state_d = (rd_en && col_last && row_last) ? DRAIN : RUN;
      DRAIN:   state_d = (!wv_q || window_ready) ? DONE : DRAIN;
      default: state_d = IDLE;
    endcase
    if (rd_en) begin
      col_d = col_last ? '0 : col_q + 1'b1;
      row_d = col_last ? (row_last ? '0 : row_q + 1'b1) : row_q;
      wv_d  = emit | wv_d;
      win_d = win_q >> DATA_W;
      for (int i = 0; i < K; i++) win_d[(i*K+K-1)*DATA_W +: DATA_W] = tap[i];
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      win_q   <= '0;
      wv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      win_q   <= win_d;
      wv_q    <= wv_d;
    end
  end
  // line buffers are never cleared: every row is rewritten before it is read
  always_ff @(posedge clk) begin
    if (rd_en) begin
      lb_q[0][col_q] <= in_feature;
      for (int m = 1; m < K-1; m++) lb_q[m][col_q] <= lb_q[m-1][col_q];
    end
  end
endmodule
